// File: rtl/iosw_pkg.sv
// Shared types and helpers for the parametrised I/O switch.
// Default field layout is {oe, inv, sel}, MSB first.
package iosw_pkg;

  localparam int unsigned DEF_NUM_PADS = 8;
  localparam int unsigned DEF_TAPS     = 4;
  localparam int unsigned DEF_SEL_W    = $clog2(DEF_TAPS);
  localparam int unsigned OE_BIT       = DEF_SEL_W + 1;
  localparam int unsigned INV_BIT      = DEF_SEL_W;

  typedef struct packed {
    logic                 oe;
    logic                 inv;
    logic [DEF_SEL_W-1:0] sel;
  } iosw_fld_t;

  localparam iosw_fld_t FLD_RST = '0;

  function automatic int unsigned cfg_len(input int unsigned num_pads,
                                          input int unsigned taps);
    return num_pads * ($clog2(taps) + 2);
  endfunction

endpackage

// File: rtl/iosw_chan.sv
// One pad channel: tap select, optional inversion, OE gating and the
// replicated pad input returned to the core while the pad is an input.
module iosw_chan
  import iosw_pkg::*;
#(
  parameter  int unsigned TAPS  = DEF_TAPS,
  localparam int unsigned SEL_W = $clog2(TAPS),
  localparam int unsigned FLD_W = SEL_W + 2
) (
  input  logic [FLD_W-1:0] fld,
  input  logic [TAPS-1:0]  taps,
  input  logic             pad_in,
  output logic             pad_out,
  output logic             pad_oe,
  output logic [TAPS-1:0]  core_in
);

  logic             oe;
  logic             inv;
  logic [SEL_W-1:0] sel;
  logic             tap;

  assign oe  = fld[SEL_W+1];
  assign inv = fld[SEL_W];
  assign sel = fld[SEL_W-1:0];

  // Selects with no matching tap fall through to tap 0.
  always_comb begin
    tap = taps[0];
    for (int unsigned i = 0; i < TAPS; i++) begin
      if (sel == SEL_W'(i)) tap = taps[i];
    end
  end

  always_comb begin
    pad_oe  = oe;
    pad_out = oe & (tap ^ inv);
    core_in = oe ? '0 : {TAPS{pad_in}};
  end

endmodule

// File: rtl/io_switch_pcfg.sv
// Double-buffered fabric I/O switch with a serial shadow config chain.
// Optional macro IOSW_OUT_REG_EN registers pad_out, pad_oe and core_in.
module io_switch_pcfg
  import iosw_pkg::*;
#(
  parameter  int unsigned NUM_PADS = DEF_NUM_PADS,
  parameter  int unsigned TAPS     = DEF_TAPS,
  localparam int unsigned SEL_W    = $clog2(TAPS),
  localparam int unsigned FLD_W    = SEL_W + 2,
  localparam int unsigned CFG_LEN  = cfg_len(NUM_PADS, TAPS),
  localparam int unsigned CORE_W   = NUM_PADS * TAPS
) (
  input  logic                prog_clk,
  input  logic                prog_rst_n,
  input  logic                prog_en,
  input  logic                prog_in,
  output logic                prog_out,
  output logic                cfg_valid,
  output logic                cfg_err,
  input  logic [CORE_W-1:0]   core_out,
  output logic [CORE_W-1:0]   core_in,
  input  logic [NUM_PADS-1:0] pad_in,
  output logic [NUM_PADS-1:0] pad_out,
  output logic [NUM_PADS-1:0] pad_oe
);

  localparam int unsigned CNT_W = $clog2(CFG_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(CFG_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CFG_LEN + 1);

  logic [CFG_LEN-1:0] shadow;
  logic [CFG_LEN-1:0] active;
  logic [CNT_W-1:0]   bcnt;
  logic               prog_en_q;

  assign prog_out = shadow[0];

  // A session ends on the first idle edge after shifting; only an exact
  // CFG_LEN-bit session is committed.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      shadow    <= '0;
      active    <= '0;
      bcnt      <= '0;
      prog_en_q <= 1'b0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      prog_en_q <= prog_en;
      if (prog_en) begin
        shadow <= {prog_in, shadow[CFG_LEN-1:1]};
        if (bcnt != CNT_SAT) bcnt <= bcnt + 1'b1;
      end else if (prog_en_q) begin
        bcnt <= '0;
        if (bcnt == CNT_LEN) begin
          active    <= shadow;
          cfg_valid <= 1'b1;
          cfg_err   <= 1'b0;
        end else begin
          cfg_err   <= 1'b1;
        end
      end
    end
  end

  logic [NUM_PADS-1:0] pad_out_c;
  logic [NUM_PADS-1:0] pad_oe_c;
  logic [CORE_W-1:0]   core_in_c;

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_chan
    iosw_chan #(
      .TAPS (TAPS)
    ) u_chan (
      .fld     (active[CFG_LEN-1-p*FLD_W -: FLD_W]),
      .taps    (core_out[p*TAPS +: TAPS]),
      .pad_in  (pad_in[p]),
      .pad_out (pad_out_c[p]),
      .pad_oe  (pad_oe_c[p]),
      .core_in (core_in_c[p*TAPS +: TAPS])
    );
  end

`ifdef IOSW_OUT_REG_EN
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      pad_out <= '0;
      pad_oe  <= '0;
      core_in <= '0;
    end else begin
      pad_out <= pad_out_c;
      pad_oe  <= pad_oe_c;
      core_in <= core_in_c;
    end
  end
`else
  always_comb begin
    pad_out = pad_out_c;
    pad_oe  = pad_oe_c;
    core_in = core_in_c;
  end
`endif

endmodule
